// File: rtl/history_reader.sv
// rtl/history_reader.sv - read-side initiator that streams the shift-history RAM out on a valid/ready port
// Optional build macro HISTORY_READER_REVERSE_EN selects oldest-first readout (N-1 down to 0).
module history_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   count,
    output logic                  busy,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [DATA_WIDTH-1:0] ram_do,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  done
);

`ifdef HISTORY_READER_REVERSE_EN
    localparam bit REVERSE = 1'b1;
`else
    localparam bit REVERSE = 1'b0;
`endif

    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] ONE_C   = (ADDR_WIDTH + 1)'(1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, PRESENT} state_t;

    state_t                state, state_d;
    logic                  busy_d, ram_en_d, out_valid_d, out_last_d, done_d;
    logic [ADDR_WIDTH-1:0] ram_addr_d;
    logic [DATA_WIDTH-1:0] out_data_d;
    logic [ADDR_WIDTH:0]   remaining, remaining_d;
    logic [ADDR_WIDTH:0]   eff_count;
    logic [ADDR_WIDTH-1:0] first_addr, next_addr;
    logic                  accept, handshake;

    // A start coinciding with done is dropped so back-to-back readouts stay separated.
    assign accept    = (state == IDLE) && start && !done;
    assign handshake = (state == PRESENT) && out_valid && out_ready;
    assign ram_we    = 1'b0;

    always_comb begin
        eff_count = count;
        if ((count == '0) || (count > DEPTH_C)) begin
            eff_count = DEPTH_C;
        end
    end

    always_comb begin
        if (REVERSE) begin
            first_addr = ADDR_WIDTH'(eff_count - ONE_C);
            next_addr  = ram_addr - 1'b1;
        end else begin
            first_addr = '0;
            next_addr  = ram_addr + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (accept) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    state_d = PRESENT;
            PRESENT: if (handshake) state_d = out_last ? IDLE : ISSUE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_d      = busy;
        ram_en_d    = 1'b0;
        ram_addr_d  = ram_addr;
        out_valid_d = out_valid;
        out_data_d  = out_data;
        out_last_d  = out_last;
        done_d      = 1'b0;
        remaining_d = remaining;
        case (state)
            IDLE: begin
                if (accept) begin
                    busy_d      = 1'b1;
                    ram_en_d    = 1'b1;
                    ram_addr_d  = first_addr;
                    remaining_d = eff_count;
                end
            end
            WAIT: begin
                // RAM data is valid exactly in this cycle, one after the enable.
                out_data_d  = ram_do;
                out_valid_d = 1'b1;
                out_last_d  = (remaining == ONE_C);
            end
            PRESENT: begin
                if (handshake) begin
                    out_valid_d = 1'b0;
                    if (out_last) begin
                        out_last_d  = 1'b0;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                        remaining_d = '0;
                    end else begin
                        ram_en_d    = 1'b1;
                        ram_addr_d  = next_addr;
                        remaining_d = remaining - ONE_C;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy      <= 1'b0;
            ram_en    <= 1'b0;
            ram_addr  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            done      <= 1'b0;
            remaining <= '0;
        end else begin
            busy      <= busy_d;
            ram_en    <= ram_en_d;
            ram_addr  <= ram_addr_d;
            out_valid <= out_valid_d;
            out_data  <= out_data_d;
            out_last  <= out_last_d;
            done      <= done_d;
            remaining <= remaining_d;
        end
    end

endmodule

// File: tb/tb_history_reader.sv
// tb/tb_history_reader.sv - directed self-checking bench for history_reader
module tb_history_reader;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [3:0] count = 4'd0;
    logic       out_ready = 1'b0;
    logic [7:0] ram_do = 8'd0;
    logic       busy, ram_en, ram_we, out_valid, out_last, done;
    logic [2:0] ram_addr;
    logic [7:0] out_data;
    logic [7:0] mem [8];

    int checks = 0;
    int failures = 0;

    int n_words, n_en, n_busy, n_done, n_we, first_valid, last_hs, done_cyc, stall_bad;
    logic [7:0] w_data [16];
    logic       w_last [16];
    logic [2:0] en_addr [16];

    history_reader #(.DATA_WIDTH(8), .DEPTH(8), .ADDR_WIDTH(3)) dut (
        .clock(clock), .reset(reset), .start(start), .count(count),
        .busy(busy), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_do(ram_do), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .done(done)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (ram_en) ram_do <= mem[ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at the first negedge after the start edge; cycle 1 is the ISSUE cycle.
    task automatic collect(input int stall, input int restart_at);
        int stall_left;
        logic [7:0] held;
        n_words = 0; n_en = 0; n_busy = 0; n_done = 0; n_we = 0;
        first_valid = -1; last_hs = -1; done_cyc = -1; stall_bad = 0;
        stall_left = stall;
        held = 8'h00;
        for (int cyc = 1; cyc < 200; cyc++) begin
            start = (cyc == restart_at);
            if (cyc == restart_at) count = 4'd1;
            if (out_valid && stall_left > 0) begin
                out_ready = 1'b0;
                if (stall_left == stall) held = out_data;
                else if (out_data !== held) stall_bad++;
                if (ram_en) stall_bad++;
                stall_left--;
            end else begin
                out_ready = 1'b1;
            end
            if (ram_en) begin
                if (n_en < 16) en_addr[n_en] = ram_addr;
                n_en++;
            end
            if (busy) n_busy++;
            if (ram_we) n_we++;
            if (out_valid && first_valid < 0) first_valid = cyc;
            if (out_valid && out_ready) begin
                if (n_words < 16) begin
                    w_data[n_words] = out_data;
                    w_last[n_words] = out_last;
                end
                n_words++;
                last_hs = cyc;
            end
            if (done) begin
                n_done++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
            @(negedge clock);
        end
        start = 1'b0;
    endtask

    task automatic verify(input string tag, input int n, input int stall);
        int a;
        logic [7:0] exp_d;
        check({tag, "_finished"}, 32'(done_cyc >= 0), 32'd1);
        check({tag, "_words"}, 32'(n_words), 32'(n));
        check({tag, "_en_cycles"}, 32'(n_en), 32'(n));
        for (int i = 0; i < n && i < 16 && i < n_words; i++) begin
`ifdef HISTORY_READER_REVERSE_EN
            a = n - 1 - i;
`else
            a = i;
`endif
            exp_d = 8'(17 * (a + 1));
            check($sformatf("%s_data%0d", tag, i), 32'(w_data[i]), 32'(exp_d));
            check($sformatf("%s_last%0d", tag, i), 32'(w_last[i]), 32'(i == n - 1));
            if (i < n_en) check($sformatf("%s_addr%0d", tag, i), 32'(en_addr[i]), 32'(a));
        end
        check({tag, "_done_pulses"}, 32'(n_done), 32'd1);
        check({tag, "_done_timing"}, 32'(done_cyc), 32'(last_hs + 1));
        check({tag, "_first_valid"}, 32'(first_valid), 32'd3);
        check({tag, "_busy_cycles"}, 32'(n_busy), 32'(3 * n + stall));
        check({tag, "_we_seen"}, 32'(n_we), 32'd0);
        check({tag, "_stall_hold"}, 32'(stall_bad), 32'd0);
    endtask

    task automatic launch(input logic [3:0] c);
        @(negedge clock);
        start = 1'b1;
        count = c;
        @(negedge clock);
        start = 1'b0;
    endtask

    initial begin
        int seen;
        for (int i = 0; i < 8; i++) mem[i] = 8'(17 * (i + 1));

        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_en", 32'(ram_en), 32'd0);
        check("rst_addr", 32'(ram_addr), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_last", 32'(out_last), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        launch(4'd0);
        check("c0_issue_busy", 32'(busy), 32'd1);
        check("c0_issue_en", 32'(ram_en), 32'd1);
        collect(0, 0);
        verify("c0", 8, 0);
        check("c0_data_held", 32'(out_data), 32'h88);

        launch(4'd3);
        collect(0, 0);
        verify("c3", 3, 0);

        launch(4'd2);
        collect(5, 0);
        verify("c2stall", 2, 5);

        launch(4'd4);
        collect(0, 4);
        verify("c4restart", 4, 0);

        launch(4'd9);
        collect(0, 0);
        verify("c9clamp", 8, 0);

        launch(4'd2);
        out_ready = 1'b0;
        seen = 0;
        for (int i = 0; i < 10 && seen == 0; i++) begin
            if (out_valid) seen = 1;
            else @(negedge clock);
        end
        check("rstmid_present", 32'(seen), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_valid", 32'(out_valid), 32'd0);
        check("rstmid_data", 32'(out_data), 32'd0);
        check("rstmid_last", 32'(out_last), 32'd0);
        check("rstmid_en", 32'(ram_en), 32'd0);
        check("rstmid_done", 32'(done), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (done || busy) seen++;
        end
        check("rstmid_quiet", 32'(seen), 32'd0);

        launch(4'd1);
        collect(0, 0);
        verify("after_rst", 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/history_reader.md
Name: history_reader

Overview:
- Read-side initiator for the 8-entry shift-history RAM.
- On a start pulse it walks the RAM addresses and issues read cycles (en=1, we=0).
- It captures each word after the RAM's one-cycle read latency and streams the words out on a valid/ready interface, with a last flag on the final word.
- While busy it holds off the upstream writer, so the history stays frozen during readout.

Parameters:
- DATA_WIDTH, 8, width of RAM words and out_data.
- DEPTH, 8, number of RAM entries; must be 2**ADDR_WIDTH.
- ADDR_WIDTH, 3, width of ram_addr.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to begin a readout.
- count  in  ADDR_WIDTH+1  number of words to read; 0 or any value >DEPTH means DEPTH.
- busy  out  1  high from the cycle after start is accepted until done; the writer must not assert we while busy=1.
- ram_en  out  1  RAM enable; high for exactly one cycle per word.
- ram_we  out  1  tied 0.
- ram_addr  out  ADDR_WIDTH  RAM read address.
- ram_do  in  DATA_WIDTH  RAM read data; valid one cycle after ram_en.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts the word.
- out_data  out  DATA_WIDTH  streamed word.
- out_last  out  1  qualifies the final word of the readout.
- done  out  1  one-cycle pulse after the last handshake.

Behaviour:
- All outputs are registered.
- Reset (reset=0, asynchronous): state=IDLE, busy=0, ram_en=0, ram_addr=0, out_valid=0, out_data=0, out_last=0, done=0, internal remaining-count=0. This holds in every state; a readout in progress is abandoned with no done pulse.
- FSM states: IDLE, ISSUE, WAIT, PRESENT.
- IDLE: start=1 at edge E0 latches N=effective count (clamped to 1..DEPTH) and sets ram_addr=first address. In the cycle after E0 the FSM is in ISSUE with busy=1 and ram_en=1.
- ISSUE, one cycle: ram_en=1 at ram_addr. Next state WAIT, with ram_en=0.
- WAIT, one cycle: ram_do is valid in this cycle. At the end of WAIT, out_data<=ram_do, out_valid<=1, and out_last<=1 if this is word N, else 0. Next state PRESENT.
- PRESENT: out_valid=1; out_data and out_last are held stable until out_valid&out_ready.
  - On handshake with out_last=0: out_valid<=0, ram_addr advances, next state ISSUE.
  - On handshake with out_last=1: out_valid<=0, out_last<=0, busy<=0, done<=1 for one cycle, next state IDLE.
- Throughput: 3 cycles per word when out_ready is held high. First out_valid appears 3 cycles after the start edge.
- start while busy=1: ignored, with no effect on count or address. start in the same cycle as done: ignored; done and start may only coincide across separate cycles.
- out_ready=1 in any state other than PRESENT has no effect.
- Address arithmetic is modulo 2**ADDR_WIDTH. The sequence is 0,1,...,N-1; address 0 is the newest entry.
- out_data keeps its last presented value after the readout. It returns to 0 only on reset.

Optional Feature:
- Macro: HISTORY_READER_REVERSE_EN.
- Defined: oldest-first readout. First address is N-1, decrementing to 0. out_last is on the word from address 0.
- Undefined: newest-first readout as described above (0 up to N-1).
- Latency, handshake and done timing are identical in both builds.

Test Plan:
- RAM preloaded with 0x11..0x88 at addr 0..7; count=0; out_ready held 1 -> 8 words 0x11,0x22,...,0x88, out_last only on 0x88, done pulse 1 cycle after the last handshake, ram_we never 1.
- count=3, out_ready=1 -> ram_addr 0,1,2 each with one ram_en cycle; first out_valid 3 cycles after start; done once; busy high for 9 cycles.
- count=2, out_ready held 0 for 5 cycles on word 0 -> out_valid/out_data=0x11 held stable for 5 cycles, no new ram_en; resumes on ready and finishes normally.
- start pulsed again mid-readout with count=1 -> ignored; the original count=4 readout completes with 4 words.
- reset asserted while in PRESENT -> asynchronously busy=0, out_valid=0, out_data=0, no done; a subsequent start with count=1 returns addr 0 correctly.
- With HISTORY_READER_REVERSE_EN and count=3 -> ram_addr 2,1,0, data 0x33,0x22,0x11, out_last on 0x11.
